// File: rtl/font_pkg.sv
// Shared definitions for the font name-table writer.
//   - Name-table geometry: 64 columns x 32 rows, {row,col} addressing.
//   - Control opcodes carried in cmd_code[3:0] when cmd_code[4] is set.
//   - Writer state encoding, held as plain localparams for legacy tools.
//   - Sweep lengths for full-screen and single-row clears.
package font_pkg;

  localparam int unsigned NAME_ADDR_W = 11;
  localparam int unsigned GLYPH_W     = 4;
  localparam int unsigned COL_W       = 6;
  localparam int unsigned ROW_W       = 5;
  localparam int unsigned CMD_W       = 5;
  localparam int unsigned SWEEP_LEN_W = 12;  // must hold 2048

  localparam int unsigned CMD_CTRL_BIT = 4;

  localparam logic [GLYPH_W-1:0] OP_NEWLINE = 4'd0;
  localparam logic [GLYPH_W-1:0] OP_HOME    = 4'd1;
  localparam logic [GLYPH_W-1:0] OP_CLS     = 4'd2;
  localparam logic [GLYPH_W-1:0] OP_BKSP    = 4'd3;
  localparam logic [GLYPH_W-1:0] OP_TOGGLE  = 4'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_ROWCLR = 2'd2;

  localparam logic [SWEEP_LEN_W-1:0] FULL_LEN = 12'd2048;
  localparam logic [SWEEP_LEN_W-1:0] ROW_LEN  = 12'd64;

  function automatic logic [NAME_ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                       input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

  function automatic logic [NAME_ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
    return {row, {COL_W{1'b0}}};
  endfunction

endpackage

// File: rtl/font_clear_sweeper.sv
// Address sweeper used for full-screen and single-row clears.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       load base/len and begin sweeping from offset 0
//   base        first address of the sweep
//   len         number of addresses to visit (2048 or 64)
//   addr        current sweep address (base + offset)
//   active      sweep in progress; addr is valid
//   done        one-cycle pulse coinciding with the last address
// Reset leaves the sweeper already running a full 2048-cell sweep from address 0,
// so the name table is scrubbed after every reset without an explicit start.
module font_clear_sweeper
  import font_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NAME_ADDR_W-1:0] base,
  input  logic [SWEEP_LEN_W-1:0] len,
  output logic [NAME_ADDR_W-1:0] addr,
  output logic                   active,
  output logic                   done
);

  logic [NAME_ADDR_W-1:0] cnt_q;
  logic [NAME_ADDR_W-1:0] base_q;
  logic [SWEEP_LEN_W-1:0] len_q;
  logic                   active_q;
  logic                   last;

  assign last   = active_q && ({1'b0, cnt_q} == (len_q - SWEEP_LEN_W'(1)));
  assign addr   = base_q + cnt_q;
  assign active = active_q;
  assign done   = last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      base_q   <= '0;
      len_q    <= FULL_LEN;
      active_q <= 1'b1;
    end else if (start) begin
      cnt_q    <= '0;
      base_q   <= base;
      len_q    <= len;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (last) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + NAME_ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/font_text_writer.sv
// Write-side master for the 64x32 font name-table RAM read by the text overlay.
// Accepts a glyph/command stream over valid/ready, keeps a cursor and writes one
// cell per cycle at waddr = {row, col}.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   cmd_valid      command present
//   cmd_ready      command accepted on an edge where cmd_valid && cmd_ready
//   cmd_code       [4]=ctrl; [3:0]=glyph (ctrl=0) or opcode (ctrl=1)
//   waddr, wdata   name-table write address and glyph
//   wenable        write strobe
//   change_active  one-cycle pulse toggling overlay visibility
//   cursor_col/row current cursor position
//   busy           clear sweep in progress (~cmd_ready)
// Build option: FONT_WRITER_ROWCLR_EN clears the full new row (64 cells) whenever
// the cursor moves to a new row through wrap or NEWLINE.
module font_text_writer
  import font_pkg::*;
#(
  parameter int unsigned         COLS        = 40,
  parameter int unsigned         ROWS        = 30,
  parameter logic [GLYPH_W-1:0]  CLEAR_GLYPH = 4'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CMD_W-1:0]       cmd_code,
  output logic [NAME_ADDR_W-1:0] waddr,
  output logic [GLYPH_W-1:0]     wdata,
  output logic                   wenable,
  output logic                   change_active,
  output logic [COL_W-1:0]       cursor_col,
  output logic [ROW_W-1:0]       cursor_row,
  output logic                   busy
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [1:0]             state_q, state_d;
  logic [NAME_ADDR_W-1:0] waddr_q, waddr_d;
  logic [GLYPH_W-1:0]     wdata_q, wdata_d;
  logic                   wenable_q, wenable_d;
  logic                   change_q, change_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;

  logic                   sweep_start;
  logic [NAME_ADDR_W-1:0] sweep_base;
  logic [SWEEP_LEN_W-1:0] sweep_len;
  logic [NAME_ADDR_W-1:0] sweep_addr;
  logic                   sweep_active;
  logic                   sweep_done;

  logic                   accept;
  logic [GLYPH_W-1:0]     cmd_low;
  logic [ROW_W-1:0]       nl_row;
  logic [COL_W-1:0]       adv_col;
  logic [ROW_W-1:0]       adv_row;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_low   = cmd_code[GLYPH_W-1:0];

  // Row below the cursor, wrapping from the last visible row to the top.
  assign nl_row = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);

  // Cursor position after a glyph write.
  always_comb begin
    if (col_q == LAST_COL) begin
      adv_col = '0;
      adv_row = nl_row;
    end else begin
      adv_col = col_q + COL_W'(1);
      adv_row = row_q;
    end
  end

  font_clear_sweeper u_sweeper (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (sweep_start),
    .base   (sweep_base),
    .len    (sweep_len),
    .addr   (sweep_addr),
    .active (sweep_active),
    .done   (sweep_done)
  );

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wenable_d   = 1'b0;
    change_d    = 1'b0;
    col_d       = col_q;
    row_d       = row_q;
    sweep_start = 1'b0;
    sweep_base  = '0;
    sweep_len   = FULL_LEN;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!cmd_code[CMD_CTRL_BIT]) begin
            wenable_d = 1'b1;
            waddr_d   = cell_addr(row_q, col_q);
            wdata_d   = cmd_low;
            col_d     = adv_col;
            row_d     = adv_row;
`ifdef FONT_WRITER_ROWCLR_EN
            if (col_q == LAST_COL) begin
              state_d     = ST_ROWCLR;
              sweep_start = 1'b1;
              sweep_base  = row_base(adv_row);
              sweep_len   = ROW_LEN;
            end
`endif
          end else begin
            case (cmd_low)
              OP_NEWLINE: begin
                col_d = '0;
                row_d = nl_row;
`ifdef FONT_WRITER_ROWCLR_EN
                state_d     = ST_ROWCLR;
                sweep_start = 1'b1;
                sweep_base  = row_base(nl_row);
                sweep_len   = ROW_LEN;
`endif
              end
              OP_HOME: begin
                col_d = '0;
                row_d = '0;
              end
              OP_CLS: begin
                state_d     = ST_CLEAR;
                sweep_start = 1'b1;
                sweep_base  = '0;
                sweep_len   = FULL_LEN;
              end
              OP_BKSP: begin
                // Backspace never reverses onto the previous row.
                if (col_q != '0) begin
                  col_d     = col_q - COL_W'(1);
                  wenable_d = 1'b1;
                  waddr_d   = cell_addr(row_q, col_q - COL_W'(1));
                  wdata_d   = CLEAR_GLYPH;
                end
              end
              OP_TOGGLE: change_d = 1'b1;
              default: ;
            endcase
          end
        end
      end

      ST_CLEAR: begin
        if (sweep_active) begin
          wenable_d = 1'b1;
          waddr_d   = sweep_addr;
          wdata_d   = CLEAR_GLYPH;
          if (sweep_done) begin
            state_d = ST_IDLE;
            col_d   = '0;
            row_d   = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

`ifdef FONT_WRITER_ROWCLR_EN
      ST_ROWCLR: begin
        // Cursor already sits at col 0 of the row being cleared.
        if (sweep_active) begin
          wenable_d = 1'b1;
          waddr_d   = sweep_addr;
          wdata_d   = CLEAR_GLYPH;
          if (sweep_done) begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wenable_q <= 1'b0;
      change_q  <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wenable_q <= wenable_d;
      change_q  <= change_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  assign waddr         = waddr_q;
  assign wdata         = wdata_q;
  assign wenable       = wenable_q;
  assign change_active = change_q;
  assign cursor_col    = col_q;
  assign cursor_row    = row_q;

endmodule

// File: tb/tb_font_text_writer.sv
// Directed self-checking bench for font_text_writer.
module tb_font_text_writer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_code;
  logic [10:0] waddr;
  logic [3:0]  wdata;
  logic        wenable;
  logic        change_active;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  font_text_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_code      (cmd_code),
    .waddr         (waddr),
    .wdata         (wdata),
    .wenable       (wenable),
    .change_active (change_active),
    .cursor_col    (cursor_col),
    .cursor_row    (cursor_row),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for cmd_ready, then present one command for one edge.
  task automatic send(input logic [4:0] code);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 5000) begin
      tick();
      w++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_code  = code;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int low;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = '0;
    #23;

    // Reset state
    check("rst_wenable", {31'd0, wenable}, 32'd0);
    check("rst_waddr", {21'd0, waddr}, 32'd0);
    check("rst_wdata", {28'd0, wdata}, 32'd0);
    check("rst_change", {31'd0, change_active}, 32'd0);
    check("rst_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // 1: power-on sweep of all 2048 cells
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      tick();
      if (wenable !== 1'b1 || waddr !== 11'(i) || wdata !== 4'h0) bad++;
      if (i == 0) check("sweep_ready_low", {31'd0, cmd_ready}, 32'd0);
    end
    check("sweep_bad_cells", bad, 32'd0);
    tick();
    check("sweep_end_wenable", {31'd0, wenable}, 32'd0);
    check("sweep_end_ready", {31'd0, cmd_ready}, 32'd1);
    check("sweep_end_busy", {31'd0, busy}, 32'd0);
    check("sweep_end_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);

    // 2: back-to-back glyphs 5,6,7
    cmd_valid = 1'b1;
    cmd_code  = 5'h05;
    tick();
    check("b2b_0", {16'd0, wenable, waddr, wdata}, {16'd0, 1'b1, 11'd0, 4'h5});
    cmd_code = 5'h06;
    tick();
    check("b2b_1", {16'd0, wenable, waddr, wdata}, {16'd0, 1'b1, 11'd1, 4'h6});
    cmd_code = 5'h07;
    tick();
    check("b2b_2", {16'd0, wenable, waddr, wdata}, {16'd0, 1'b1, 11'd2, 4'h7});
    cmd_valid = 1'b0;
    check("b2b_col", {26'd0, cursor_col}, 32'd3);
    tick();
    check("b2b_idle_wenable", {31'd0, wenable}, 32'd0);

    // 4: backspace at col 3, then at col 0
    send(5'h13);
    check("bksp_write", {16'd0, wenable, waddr, wdata}, {16'd0, 1'b1, 11'd2, 4'h0});
    check("bksp_col", {26'd0, cursor_col}, 32'd2);
    send(5'h11);
    check("home_nowrite", {31'd0, wenable}, 32'd0);
    check("home_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
    send(5'h13);
    check("bksp0_nowrite", {31'd0, wenable}, 32'd0);
    check("bksp0_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);

    // 3: 40 glyphs across row 0, then wrap from the last row
    bad = 0;
    cmd_valid = 1'b1;
    cmd_code  = 5'h09;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wenable !== 1'b1 || waddr !== 11'(i) || wdata !== 4'h9) bad++;
    end
    cmd_valid = 1'b0;
    check("row0_bad_writes", bad, 32'd0);
    check("row0_last_addr", {21'd0, waddr}, 32'd39);
    check("row0_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd1, 6'd0});
    for (int i = 0; i < 28; i++) send(5'h10);
    for (int i = 0; i < 39; i++) send(5'h02);
    check("pre_wrap_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd29, 6'd39});
    send(5'h0A);
    check("wrap_write", {16'd0, wenable, waddr, wdata}, {16'd0, 1'b1, 11'h767, 4'hA});
    check("wrap_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);

    // 5: toggle pulse and ignored opcode
    send(5'h14);
    check("toggle_hi", {31'd0, change_active}, 32'd1);
    check("toggle_nowrite", {31'd0, wenable}, 32'd0);
    tick();
    check("toggle_lo", {31'd0, change_active}, 32'd0);
    send(5'h03);
    send(5'h17);
    check("ignored_nowrite", {31'd0, wenable}, 32'd0);
    check("ignored_change", {31'd0, change_active}, 32'd0);
    check("ignored_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd0, 6'd1});

    // 6: NEWLINE from row 4
    for (int i = 0; i < 4; i++) send(5'h10);
    send(5'h11);
    for (int i = 0; i < 4; i++) send(5'h10);
    check("pre_nl_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd4, 6'd0});
    send(5'h10);
    check("nl_cursor", {21'd0, cursor_row, cursor_col}, {21'd0, 5'd5, 6'd0});
`ifdef FONT_WRITER_ROWCLR_EN
    check("rowclr_first_idle", {31'd0, wenable}, 32'd0);
    bad = 0;
    low = (cmd_ready === 1'b0) ? 1 : 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (wenable !== 1'b1 || waddr !== 11'(11'h140 + i) || wdata !== 4'h0) bad++;
      if (cmd_ready === 1'b0) low++;
    end
    check("rowclr_bad_writes", bad, 32'd0);
    check("rowclr_ready_low", low, 32'd64);
    tick();
    check("rowclr_done_ready", {31'd0, cmd_ready}, 32'd1);
`else
    check("nl_nowrite", {31'd0, wenable}, 32'd0);
    check("nl_ready", {31'd0, cmd_ready}, 32'd1);
`endif

    // 5: CLS interrupted by reset at sweep cycle 1000
    send(5'h12);
    check("cls_ready_drop", {31'd0, cmd_ready}, 32'd0);
    check("cls_busy", {31'd0, busy}, 32'd1);
    repeat (1000) tick();
    check("cls_progress", {20'd0, wenable, waddr}, {20'd0, 1'b1, 11'd999});
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wenable", {31'd0, wenable}, 32'd0);
    check("midrst_waddr", {21'd0, waddr}, 32'd0);
    check("midrst_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    #3;
    rst_n = 1'b1;
    tick();
    check("restart_addr0", {20'd0, wenable, waddr}, {20'd0, 1'b1, 11'd0});
    tick();
    check("restart_addr1", {20'd0, wenable, waddr}, {20'd0, 1'b1, 11'd1});
    check("restart_ready", {31'd0, cmd_ready}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
